// File: rtl/mem_bus_arbiter_if.sv
// Shared data-memory bus bundle between the two requesters,
// the arbiter and the address decoder.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;

  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_memWrite;
  logic        bus_memToReg;
  logic [31:0] bus_rdata;
  logic        bus_owner;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output bus_addr, bus_data, bus_memWrite, bus_memToReg,
    input  bus_rdata,
    output bus_owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  bus_addr, bus_data, bus_memWrite, bus_memToReg,
    output bus_rdata,
    input  bus_owner, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the data-memory bus: CPU-first priority,
// starvation counter, region latency, one-cycle ack.
module mem_bus_arbiter #(
  parameter int unsigned HD_LAT     = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] HD_CNT = 4'(HD_LAT);
  localparam logic [7:0] STV_LIM = 8'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [7:0]  starve_q, starve_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] bdata_q, bdata_d;
  logic        bwr_q, bwr_d;
  logic        brd_q, brd_d;
  logic        cack_q, cack_d;
  logic        dack_q, dack_d;
  logic [31:0] crd_q, crd_d;
  logic [31:0] drd_q, drd_d;

  logic        gnt_dma;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_hd;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    cnt_d     = cnt_q;
    baddr_d   = baddr_q;
    bdata_d   = bdata_q;
    bwr_d     = bwr_q;
    brd_d     = brd_q;
    cack_d    = 1'b0;
    dack_d    = 1'b0;
    crd_d     = crd_q;
    drd_d     = drd_q;
    gnt_dma   = bus.dma_req &
                (~bus.cpu_req | (starve_q == STV_LIM));
    sel_we    = gnt_dma ? bus.dma_we : bus.cpu_we;
    sel_addr  = gnt_dma ? bus.dma_addr : bus.cpu_addr;
    sel_wdata = gnt_dma ? bus.dma_wdata : bus.cpu_wdata;
    sel_hd    = (sel_addr[15:8] >= 8'h23) &&
                (sel_addr[15:8] <= 8'h62);
    unique case (state_q)
      IDLE: begin
        if (!bus.dma_req) starve_d = '0;
        if (bus.cpu_req || bus.dma_req) begin
          state_d  = ACCESS;
          owner_d  = gnt_dma;
          starve_d = (gnt_dma || !bus.dma_req) ?
                     8'd0 : starve_q + 8'd1;
          cnt_d    = sel_hd ? HD_CNT : 4'd1;
          baddr_d  = sel_addr;
          bdata_d  = sel_we ? sel_wdata : 32'd0;
          bwr_d    = sel_we;
          brd_d    = ~sel_we;
        end
      end
      ACCESS: begin
        bwr_d = 1'b0;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          baddr_d = '0;
          bdata_d = '0;
          brd_d   = 1'b0;
          if (owner_q) begin
            dack_d = 1'b1;
            drd_d  = bus.bus_rdata;
          end else begin
            cack_d = 1'b1;
            crd_d  = bus.bus_rdata;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      cnt_q    <= '0;
      baddr_q  <= '0;
      bdata_q  <= '0;
      bwr_q    <= 1'b0;
      brd_q    <= 1'b0;
      cack_q   <= 1'b0;
      dack_q   <= 1'b0;
      crd_q    <= '0;
      drd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
      baddr_q  <= baddr_d;
      bdata_q  <= bdata_d;
      bwr_q    <= bwr_d;
      brd_q    <= brd_d;
      cack_q   <= cack_d;
      dack_q   <= dack_d;
      crd_q    <= crd_d;
      drd_q    <= drd_d;
    end
  end

  assign bus.cpu_ack      = cack_q;
  assign bus.cpu_rdata    = crd_q;
  assign bus.cpu_stall    = rst_n & bus.cpu_req & ~cack_q;
  assign bus.dma_ack      = dack_q;
  assign bus.dma_rdata    = drd_q;
  assign bus.bus_addr     = baddr_q;
  assign bus.bus_data     = bdata_q;
  assign bus.bus_memWrite = bwr_q;
  assign bus.bus_memToReg = brd_q;
  assign bus.bus_owner    = owner_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (HD_LAT=4, STARVE_MAX=8).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mem_bus_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_bus_arbiter_if bif ();

  mem_bus_arbiter #(
    .HD_LAT     (4),
    .STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bif.cpu_req   = 1'b0;
    bif.cpu_we    = 1'b0;
    bif.cpu_addr  = '0;
    bif.cpu_wdata = '0;
    bif.dma_req   = 1'b0;
    bif.dma_we    = 1'b0;
    bif.dma_addr  = '0;
    bif.dma_wdata = '0;
    bif.bus_rdata = '0;
    tick();
    tick();
    checks++;
    if ({bif.bus_addr, bif.bus_data, bif.cpu_rdata,
         bif.dma_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h exp 0",
               bif.bus_addr, bif.bus_data);
    end
    checks++;
    if ({bif.bus_memWrite, bif.bus_memToReg, bif.bus_owner,
         bif.busy, bif.cpu_ack, bif.dma_ack, bif.cpu_stall}
        !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got nonzero exp 0");
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = 1'b0;
    bif.cpu_addr  = 32'h0000_0010;
    bif.bus_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bif.cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL rd_stall_c1: got %b exp 1", bif.cpu_stall);
    end
    tick();
    checks++;
    if ({bif.busy, bif.bus_owner, bif.bus_memWrite,
         bif.bus_memToReg, bif.cpu_stall, bif.cpu_ack}
        !== 6'b100110) begin
      errors++;
      $display("FAIL rd_access_ctrl: got %b exp 100110",
               {bif.busy, bif.bus_owner, bif.bus_memWrite,
                bif.bus_memToReg, bif.cpu_stall, bif.cpu_ack});
    end
    checks++;
    if ({bif.bus_addr, bif.bus_data} !== {32'h10, 32'h0}) begin
      errors++;
      $display("FAIL rd_access_bus: got %h %h exp 10 0",
               bif.bus_addr, bif.bus_data);
    end
    tick();
    checks++;
    if ({bif.cpu_ack, bif.cpu_stall, bif.busy,
         bif.bus_memToReg} !== 4'b1010) begin
      errors++;
      $display("FAIL rd_resp_ctrl: got %b exp 1010",
               {bif.cpu_ack, bif.cpu_stall, bif.busy,
                bif.bus_memToReg});
    end
    checks++;
    if (bif.cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_resp_data: got %h exp deadbeef",
               bif.cpu_rdata);
    end
    bif.cpu_req = 1'b0;
    tick();
    checks++;
    if ({bif.cpu_ack, bif.busy} !== 2'b00) begin
      errors++;
      $display("FAIL rd_idle: got %b exp 00",
               {bif.cpu_ack, bif.busy});
    end
  endtask

  task automatic test_dma_hd_write();
    bif.dma_req   = 1'b1;
    bif.dma_we    = 1'b1;
    bif.dma_addr  = 32'h0000_2400;
    bif.dma_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bif.bus_addr, bif.bus_data, bif.bus_owner,
           bif.bus_memWrite, bif.bus_memToReg, bif.dma_ack}
          !== {32'h2400, 32'h1234_5678, 1'b1,
               (i == 0), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hdwr_access%0d: got %h %h wr=%b ack=%b",
                 i, bif.bus_addr, bif.bus_data,
                 bif.bus_memWrite, bif.dma_ack);
      end
    end
    tick();
    checks++;
    if ({bif.dma_ack, bif.cpu_ack, bif.bus_owner,
         bif.bus_memWrite} !== 4'b1010 ||
        bif.bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL hdwr_resp: got ack=%b addr=%h exp 1 0",
               bif.dma_ack, bif.bus_addr);
    end
    bif.dma_req = 1'b0;
    bif.dma_we  = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic        exp_dma;
    logic [31:0] exp_addr;
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = 1'b0;
    bif.cpu_addr  = 32'h0000_0100;
    bif.dma_req   = 1'b1;
    bif.dma_we    = 1'b0;
    bif.dma_addr  = 32'h0000_0200;
    bif.bus_rdata = 32'h0;
    for (int k = 0; k < 18; k++) begin
      exp_dma  = (k % 9 == 8);
      exp_addr = exp_dma ? 32'h200 : 32'h100;
      tick();
      checks++;
      if ({bif.bus_owner, bif.bus_addr} !==
          {exp_dma, exp_addr}) begin
        errors++;
        $display("FAIL starve_grant%0d: got %b %h exp %b %h",
                 k, bif.bus_owner, bif.bus_addr,
                 exp_dma, exp_addr);
      end
      tick();
      checks++;
      if ({bif.cpu_ack, bif.dma_ack, bif.cpu_stall} !==
          {~exp_dma, exp_dma, exp_dma}) begin
        errors++;
        $display("FAIL starve_ack%0d: got %b exp %b", k,
                 {bif.cpu_ack, bif.dma_ack, bif.cpu_stall},
                 {~exp_dma, exp_dma, exp_dma});
      end
      if (k == 17) begin
        bif.cpu_req = 1'b0;
        bif.dma_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_late_cpu();
    bif.dma_req   = 1'b1;
    bif.dma_we    = 1'b0;
    bif.dma_addr  = 32'h0000_3000;
    bif.bus_rdata = 32'hCAFE_0001;
    tick();
    tick();
    bif.cpu_req  = 1'b1;
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 32'h0000_0040;
    #1;
    checks++;
    if ({bif.bus_owner, bif.cpu_stall, bif.cpu_ack} !== 3'b110)
    begin
      errors++;
      $display("FAIL late_a2: got %b exp 110",
               {bif.bus_owner, bif.cpu_stall, bif.cpu_ack});
    end
    tick();
    tick();
    checks++;
    if ({bif.bus_owner, bif.bus_addr, bif.cpu_ack} !==
        {1'b1, 32'h3000, 1'b0}) begin
      errors++;
      $display("FAIL late_a4: got %b %h %b", bif.bus_owner,
               bif.bus_addr, bif.cpu_ack);
    end
    tick();
    checks++;
    if ({bif.dma_ack, bif.cpu_ack, bif.dma_rdata} !==
        {2'b10, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL late_dresp: got %b%b %h exp 10 cafe0001",
               bif.dma_ack, bif.cpu_ack, bif.dma_rdata);
    end
    bif.dma_req   = 1'b0;
    bif.bus_rdata = 32'h0BAD_F00D;
    tick();
    checks++;
    if ({bif.busy, bif.cpu_ack, bif.cpu_stall} !== 3'b001) begin
      errors++;
      $display("FAIL late_idle: got %b exp 001",
               {bif.busy, bif.cpu_ack, bif.cpu_stall});
    end
    tick();
    checks++;
    if ({bif.bus_owner, bif.bus_addr} !== {1'b0, 32'h40}) begin
      errors++;
      $display("FAIL late_cgrant: got %b %h exp 0 40",
               bif.bus_owner, bif.bus_addr);
    end
    tick();
    checks++;
    if ({bif.cpu_ack, bif.cpu_rdata, bif.dma_rdata} !==
        {1'b1, 32'h0BAD_F00D, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL late_cresp: got %b %h %h", bif.cpu_ack,
               bif.cpu_rdata, bif.dma_rdata);
    end
    bif.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    bif.dma_req   = 1'b1;
    bif.dma_we    = 1'b0;
    bif.dma_addr  = 32'h0000_2500;
    bif.bus_rdata = 32'h1111_2222;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.busy, bif.bus_owner, bif.bus_memToReg,
         bif.dma_ack, bif.bus_addr, bif.dma_rdata} !== 68'd0)
    begin
      errors++;
      $display("FAIL abort_out: got busy=%b addr=%h rd=%h",
               bif.busy, bif.bus_addr, bif.dma_rdata);
    end
    bif.dma_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bif.busy, bif.dma_ack} !== 2'b00) begin
      errors++;
      $display("FAIL abort_after: got %b exp 00",
               {bif.busy, bif.dma_ack});
    end
    bif.dma_req   = 1'b1;
    bif.bus_rdata = 32'h55AA_55AA;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bif.busy, bif.bus_owner, bif.dma_ack} !== 3'b110)
      begin
        errors++;
        $display("FAIL reissue_acc%0d: got %b exp 110", i,
                 {bif.busy, bif.bus_owner, bif.dma_ack});
      end
    end
    tick();
    checks++;
    if ({bif.dma_ack, bif.dma_rdata} !== {1'b1, 32'h55AA_55AA})
    begin
      errors++;
      $display("FAIL reissue_resp: got %b %h exp 1 55aa55aa",
               bif.dma_ack, bif.dma_rdata);
    end
    bif.dma_req = 1'b0;
    tick();
  endtask

  task automatic test_timer_write();
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = 1'b1;
    bif.cpu_addr  = 32'h0000_6304;
    bif.cpu_wdata = 32'hA5A5_0001;
    tick();
    checks++;
    if ({bif.bus_memWrite, bif.bus_memToReg, bif.bus_addr,
         bif.bus_data} !== {2'b10, 32'h6304, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL tmr_access: got %b%b %h %h",
               bif.bus_memWrite, bif.bus_memToReg,
               bif.bus_addr, bif.bus_data);
    end
    tick();
    checks++;
    if ({bif.cpu_ack, bif.bus_memWrite, bif.bus_addr} !==
        {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL tmr_resp: got ack=%b wr=%b addr=%h",
               bif.cpu_ack, bif.bus_memWrite, bif.bus_addr);
    end
    bif.cpu_req = 1'b0;
    bif.cpu_we  = 1'b0;
    tick();
  endtask

  task automatic test_region_edges();
    logic [31:0] addrs [4];
    int          lats  [4];
    int          n;
    addrs = '{32'h2200, 32'h2300, 32'h6200, 32'h6300};
    lats  = '{1, 4, 4, 1};
    for (int j = 0; j < 4; j++) begin
      bif.cpu_req  = 1'b1;
      bif.cpu_we   = 1'b0;
      bif.cpu_addr = addrs[j];
      tick();
      n = 0;
      while (bif.cpu_ack !== 1'b1 && n < 20) begin
        n++;
        tick();
      end
      checks++;
      if (n !== lats[j]) begin
        errors++;
        $display("FAIL region_%h: got %0d cycles exp %0d",
                 addrs[j], n, lats[j]);
      end
      bif.cpu_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cpu_read();
    test_dma_hd_write();
    test_starvation();
    test_late_cpu();
    test_reset_abort();
    test_timer_write();
    test_region_edges();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory bus (address decoder → RAM / instruction / video / HD / timer) between two requesters: the CPU load/store port and the DMA/loader port.
- Latches one transaction at a time and drives the decoder's addr/data/memWrite/memToReg inputs.
- Holds the bus for the region-dependent latency, then returns read data with a one-cycle ack.
- CPU has priority, with a starvation counter guaranteeing DMA progress.

Parameters:
- HD_LAT, 4, cycles a transaction to the HD region (addr[15:8] in 8'h23..8'h62) occupies the bus; legal range 1..15.
- STARVE_MAX, 8, number of consecutive CPU wins while DMA is waiting before DMA is forced to win; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU transaction request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_ack = 1.
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes the pipeline.
- dma_req, dma_we, dma_addr[32], dma_wdata[32], dma_ack, dma_rdata[32]: same semantics as the cpu_* ports.
- bus_addr  out  32  to decoder addr.
- bus_data  out  32  to decoder data.
- bus_memWrite  out  1  to decoder memWrite.
- bus_memToReg  out  1  to decoder memToReg.
- bus_rdata  in  32  read data returned from the selected memory/peripheral.
- bus_owner  out  1  0 = CPU, 1 = DMA; meaningful only while busy = 1.
- busy  out  1  high in the ACCESS and RESP states.

Behaviour:

Reset:
- While rst_n = 0: state = IDLE; all outputs 0; starvation counter 0; latched request cleared.
- Reset asserted mid-transaction aborts it. No ack is issued, and the requester must re-issue.

States:
- IDLE → ACCESS: taken when any request is present.
- ACCESS → RESP: taken when the latency counter expires.
- RESP → IDLE: always, after one cycle.

IDLE:
- req inputs are sampled only in IDLE.
- Only cpu_req = 1: grant CPU.
- Only dma_req = 1: grant DMA.
- Both requesting:
  - starve_cnt == STARVE_MAX → grant DMA.
  - Otherwise grant CPU and increment starve_cnt.
- starve_cnt clears whenever DMA is granted, and when dma_req = 0 in IDLE.
- On grant, latch owner, we, addr and wdata, then go to ACCESS.
- Latency counter loads HD_LAT if latched addr[15:8] is in 8'h23..8'h62; otherwise it loads 1.
- Unmapped addresses also take 1 cycle.

ACCESS:
- bus_addr = latched addr; bus_data = latched wdata (0 on reads).
- bus_memToReg = ~we for every ACCESS cycle.
- bus_memWrite = we in the first ACCESS cycle only: exactly one write strobe per transaction, including multi-cycle HD writes.
- Counter decrements each cycle.
- On the last ACCESS cycle (counter == 1), capture bus_rdata into the rdata register, then go to RESP.

RESP:
- The owner's ack = 1 for exactly one cycle; its rdata = captured value.
- All bus_* outputs = 0.
- The other requester's ack = 0 and its rdata holds its last value.
- Next state is IDLE.

Outside ACCESS: bus_addr, bus_data, bus_memWrite and bus_memToReg are all 0.

Timing:
- Minimum transaction is 3 cycles, req to ack: IDLE, ACCESS, RESP.
- An HD transaction takes HD_LAT + 2 cycles.
- The idle cycle between transactions is mandatory, so back-to-back throughput is one transaction per (latency + 2) cycles.

Requester protocol:
- A requester must keep req and its fields stable until ack.
- Req must be low in the cycle after ack unless a new transaction is intended; a req still high in IDLE is treated as a new request.
- Fields that change after the grant are ignored until the next IDLE.

Simultaneous events:
- A new request arriving during ACCESS or RESP waits; it is not lost, provided req is held.
- The losing requester sees stall/no ack and is unaffected otherwise.

Widths: addresses pass through unmodified; region translation belongs to the decoder.

Test Plan:
1. CPU read addr 0x0000_0010, bus_rdata = 0xDEAD_BEEF → ACCESS 1 cycle with bus_memToReg = 1, bus_memWrite = 0; cpu_ack pulses in cycle 3 with cpu_rdata = 0xDEAD_BEEF; cpu_stall high in cycles 1–2.
2. DMA write addr 0x0000_2400, data 0x1234_5678, HD_LAT = 4 → bus_memWrite high in the first ACCESS cycle only; bus_addr = 0x2400 for 4 cycles; dma_ack in cycle 6; bus_owner = 1.
3. Both requesting continuously, STARVE_MAX = 8 → grant order is 8× CPU then 1× DMA, repeating; starve_cnt returns to 0 after each DMA grant.
4. cpu_req arrives in the second ACCESS cycle of a DMA HD read → CPU granted in the IDLE after the DMA RESP; no spurious cpu_ack earlier.
5. rst_n pulsed low during the 3rd ACCESS cycle of an HD read → all outputs 0 immediately; no dma_ack; a DMA re-request completes normally afterward.
6. CPU write to timer addr 0x0000_6304 → 1-cycle ACCESS with a single bus_memWrite pulse; cpu_ack in cycle 3.
